// File: rtl/adc_frame_rx.sv
// -----------------------------------------------------------------------------
// adc_frame_rx
//
// Receive-side decoder for the multislope ADC result link. It deserialises the
// 8N1 UART stream from the ADC controller and assembles four big-endian bytes
// into a 32-bit result word. Bits 31, 29 and 28 of that word are reserved and
// must be zero. A clean word is presented as sign / run-up / run-down fields
// with a one-cycle frame_valid_o strobe. A discarded frame gives a one-cycle
// frame_err_o strobe instead.
//
// Parameters
//   CLKS_PER_BIT   mclk cycles per UART bit (>= 8)
//   IDLE_BITS      bit-times of idle-high that abort a partial frame
//
// Ports
//   mclk_i          system clock, rising edge
//   rst_i           synchronous active-high reset
//   rx_in_i         serial line, idle high, asynchronous to mclk_i
//   frame_valid_o   one-cycle strobe, fields updated with a clean frame
//   frame_err_o     one-cycle strobe, frame discarded
//   rundown_sign_o  word bit 30
//   runup_cnt_o     word bits 27:16
//   rundown_cnt_o   word bits 15:0
//   rx_busy_o       high from start-bit detection through the stop sample
//
// State     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | line idle, waiting for a falling edge; runs the idle timer
// S_START   | qualifying the start bit at mid-bit
// S_DATA    | sampling 8 data bits, LSB first
// S_STOP    | sampling the stop bit, then byte / frame bookkeeping
// S_WAIT_HI | stop-bit error seen, waiting for the line to return high
// -----------------------------------------------------------------------------
module adc_frame_rx #(
    parameter int CLKS_PER_BIT = 1600,
    parameter int IDLE_BITS    = 20
) (
    input  logic        mclk_i,
    input  logic        rst_i,
    input  logic        rx_in_i,
    output logic        frame_valid_o,
    output logic        frame_err_o,
    output logic        rundown_sign_o,
    output logic [11:0] runup_cnt_o,
    output logic [15:0] rundown_cnt_o,
    output logic        rx_busy_o
);

    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDLE_LIMIT_I = IDLE_BITS * CLKS_PER_BIT;
    localparam int IDLE_W       = $clog2(IDLE_LIMIT_I + 1);

    localparam logic [CNT_W-1:0]  HALF_BIT   = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(IDLE_LIMIT_I);
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_LIMIT_I - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HI
    } state_t;

    state_t              state_q;
    logic                rx_meta_q;
    logic                rxs_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [2:0]          bit_idx_q;
    logic [7:0]          shift_q;
    logic [1:0]          byte_idx_q;
    logic [23:0]         word_q;
    logic [IDLE_W-1:0]   idle_cnt_q;
    logic                busy_q;
    logic                frame_valid_q;
    logic                frame_err_q;
    logic                sign_q;
    logic [11:0]         runup_q;
    logic [15:0]         rundown_q;

    // Complete word as it stands once byte 3 has been shifted in.
    logic [31:0] word_d;
    logic        reserved_ok_d;

    assign word_d        = {word_q, shift_q};
    assign reserved_ok_d = ~word_d[31] & ~word_d[29] & ~word_d[28];

    always_ff @(posedge mclk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            rx_meta_q     <= 1'b1;
            rxs_q         <= 1'b1;
            bit_cnt_q     <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            byte_idx_q    <= '0;
            word_q        <= '0;
            idle_cnt_q    <= '0;
            busy_q        <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            sign_q        <= 1'b0;
            runup_q       <= '0;
            rundown_q     <= '0;
        end else begin
            rx_meta_q     <= rx_in_i;
            rxs_q         <= rx_meta_q;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (!rxs_q) begin
                        // The cycle that saw the low level is count 0, so the
                        // timer enters START already at 1.
                        state_q    <= S_START;
                        bit_cnt_q  <= CNT_W'(1);
                        idle_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end else if (idle_cnt_q != IDLE_LIMIT) begin
                        idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
                        if (idle_cnt_q == IDLE_LAST && byte_idx_q != 2'd0) begin
                            frame_err_q <= 1'b1;
                            byte_idx_q  <= 2'd0;
                        end
                    end
                end

                S_START: begin
                    if (bit_cnt_q == HALF_BIT) begin
                        bit_cnt_q <= '0;
                        if (rxs_q) begin
                            // Glitch: abandon silently, frame position kept.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= S_DATA;
                            bit_idx_q <= '0;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_q <= '0;
                        shift_q   <= {rxs_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b0;
                        if (!rxs_q) begin
                            state_q     <= S_WAIT_HI;
                            frame_err_q <= 1'b1;
                            byte_idx_q  <= 2'd0;
                        end else begin
                            // Back to IDLE straight away so a back-to-back
                            // start bit is not missed.
                            state_q <= S_IDLE;
                            unique case (byte_idx_q)
                                2'd0: word_q[23:16] <= shift_q;
                                2'd1: word_q[15:8]  <= shift_q;
                                2'd2: word_q[7:0]   <= shift_q;
                                default: begin
                                    if (reserved_ok_d) begin
                                        frame_valid_q <= 1'b1;
                                        sign_q        <= word_d[30];
                                        runup_q       <= word_d[27:16];
                                        rundown_q     <= word_d[15:0];
                                    end else begin
                                        frame_err_q <= 1'b1;
                                    end
                                end
                            endcase
                            byte_idx_q <= byte_idx_q + 2'd1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end

                S_WAIT_HI: begin
                    if (rxs_q) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign frame_valid_o  = frame_valid_q;
    assign frame_err_o    = frame_err_q;
    assign rundown_sign_o = sign_q;
    assign runup_cnt_o    = runup_q;
    assign rundown_cnt_o  = rundown_q;
    assign rx_busy_o      = busy_q;

endmodule

// File: tb/tb_adc_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_adc_frame_rx
//
// Directed bench for adc_frame_rx at CLKS_PER_BIT=16, IDLE_BITS=20. Bytes are
// driven as 8N1 on the negative clock edge. A negedge monitor counts strobe
// cycles and timestamps the rx_busy falling edge and frame_err.
// -----------------------------------------------------------------------------
module tb_adc_frame_rx;

    localparam int CPB  = 16;
    localparam int IDLB = 20;

    logic        clk;
    logic        rst;
    logic        rx;
    logic        frame_valid;
    logic        frame_err;
    logic        sign;
    logic [11:0] runup;
    logic [15:0] rundown;
    logic        busy;

    int total = 0;
    int bad   = 0;

    int cyc       = 0;
    int vcnt      = 0;
    int ecnt      = 0;
    int both      = 0;
    int t_fall    = 0;
    int t_err     = 0;
    logic prev_busy = 1'b0;

    adc_frame_rx #(
        .CLKS_PER_BIT (CPB),
        .IDLE_BITS    (IDLB)
    ) dut (
        .mclk_i         (clk),
        .rst_i          (rst),
        .rx_in_i        (rx),
        .frame_valid_o  (frame_valid),
        .frame_err_o    (frame_err),
        .rundown_sign_o (sign),
        .runup_cnt_o    (runup),
        .rundown_cnt_o  (rundown),
        .rx_busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (frame_valid) vcnt = vcnt + 1;
        if (frame_err) begin
            ecnt  = ecnt + 1;
            t_err = cyc;
        end
        if (frame_valid && frame_err) both = both + 1;
        if (prev_busy && !busy) t_fall = cyc;
        prev_busy = busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp)
        else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        wait_cyc(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_v);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [31:0] w);
        send_byte(w[31:24], 1'b1);
        send_byte(w[23:16], 1'b1);
        send_byte(w[15:8],  1'b1);
        send_byte(w[7:0],   1'b1);
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(3);

        chk("rst_valid",   {31'd0, frame_valid}, 32'd0);
        chk("rst_err",     {31'd0, frame_err},   32'd0);
        chk("rst_busy",    {31'd0, busy},        32'd0);
        chk("rst_sign",    {31'd0, sign},        32'd0);
        chk("rst_runup",   {20'd0, runup},       32'd0);
        chk("rst_rundown", {16'd0, rundown},     32'd0);

        // Clean frame, back-to-back bytes.
        send_frame(32'h400C_8123);
        wait_cyc(4);
        chk("f1_vcnt",    vcnt,               32'd1);
        chk("f1_ecnt",    ecnt,               32'd0);
        chk("f1_sign",    {31'd0, sign},      32'd1);
        chk("f1_runup",   {20'd0, runup},     32'h00C);
        chk("f1_rundown", {16'd0, rundown},   32'h8123);

        // Reserved bit 31 set: discarded, fields held.
        send_frame(32'hC000_0001);
        wait_cyc(4);
        chk("res_vcnt",    vcnt,             32'd1);
        chk("res_ecnt",    ecnt,             32'd1);
        chk("res_sign",    {31'd0, sign},    32'd1);
        chk("res_runup",   {20'd0, runup},   32'h00C);
        chk("res_rundown", {16'd0, rundown}, 32'h8123);

        // Stop-bit error on byte 2, then a clean frame.
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        wait_cyc(2 * CPB);
        chk("stop_ecnt", ecnt, 32'd2);
        chk("stop_vcnt", vcnt, 32'd1);
        send_frame(32'h007F_0010);
        wait_cyc(4);
        chk("f3_vcnt",    vcnt,             32'd2);
        chk("f3_sign",    {31'd0, sign},    32'd0);
        chk("f3_runup",   {20'd0, runup},   32'h07F);
        chk("f3_rundown", {16'd0, rundown}, 32'h0010);

        // Long idle with no partial frame: no action.
        wait_cyc(IDLB * CPB + 50);
        chk("idle0_ecnt", ecnt, 32'd2);

        // Partial frame: two bytes, then idle past the timeout.
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        wait_cyc(IDLB * CPB + 20);
        chk("part_ecnt",  ecnt,           32'd3);
        chk("part_delay", t_err - t_fall, IDLB * CPB);
        send_frame(32'h0ABC_DEF0);
        wait_cyc(4);
        chk("f4_vcnt",    vcnt,             32'd3);
        chk("f4_ecnt",    ecnt,             32'd3);
        chk("f4_sign",    {31'd0, sign},    32'd0);
        chk("f4_runup",   {20'd0, runup},   32'hABC);
        chk("f4_rundown", {16'd0, rundown}, 32'hDEF0);

        // Start glitch after byte 0; frame position must survive it.
        send_byte(8'h40, 1'b1);
        rx = 1'b0;
        wait_cyc(5);
        rx = 1'b1;
        wait_cyc(3 * CPB);
        chk("gl_busy", {31'd0, busy}, 32'd0);
        chk("gl_vcnt", vcnt,          32'd3);
        chk("gl_ecnt", ecnt,          32'd3);
        send_byte(8'h55, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        wait_cyc(4);
        chk("f5_vcnt",    vcnt,             32'd4);
        chk("f5_ecnt",    ecnt,             32'd3);
        chk("f5_sign",    {31'd0, sign},    32'd1);
        chk("f5_runup",   {20'd0, runup},   32'h055);
        chk("f5_rundown", {16'd0, rundown}, 32'h1234);

        // Reset pulse in the middle of byte 1.
        send_byte(8'h40, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        rx  = 1'b1;
        wait_cyc(3 * CPB);
        chk("r_busy",    {31'd0, busy},    32'd0);
        chk("r_sign",    {31'd0, sign},    32'd0);
        chk("r_runup",   {20'd0, runup},   32'd0);
        chk("r_rundown", {16'd0, rundown}, 32'd0);
        chk("r_vcnt",    vcnt,             32'd4);
        chk("r_ecnt",    ecnt,             32'd3);
        send_frame(32'h400C_8123);
        wait_cyc(4);
        chk("f6_vcnt",    vcnt,             32'd5);
        chk("f6_ecnt",    ecnt,             32'd3);
        chk("f6_sign",    {31'd0, sign},    32'd1);
        chk("f6_runup",   {20'd0, runup},   32'h00C);
        chk("f6_rundown", {16'd0, rundown}, 32'h8123);

        chk("never_both", both, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
